// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4-phase scan controller driving a downstream 4:1 mux and collecting its output
//
// Purpose: on an accepted start, presents d_in on d and steps select through
// 0..3. Each select value is held for DWELL cycles, and the returned mux output
// q is captured into word[select] on the last cycle of that hold.
// Optional feature macro: MUX_SCAN_CHECK_EN (compares the final word against d into err).
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   scan request, sampled in IDLE only
//   d_in    in   [3:0] data word, captured on accepted start
//   q       in   downstream mux output
//   d       out  [3:0] registered mux data bus
//   select  out  [1:0] registered mux select
//   busy    out  high in SCAN and DONE
//   done    out  one-cycle completion pulse
//   word    out  [3:0] captured result, bit k = q sampled while select==k
//   err     out  final word != d (MUX_SCAN_CHECK_EN), otherwise constant 0

module mux_scan_ctrl #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d_in,
    input  logic       q,
    output logic [3:0] d,
    output logic [1:0] select,
    output logic       busy,
    output logic       done,
    output logic [3:0] word,
    output logic       err
);

    localparam int            CW   = (DWELL <= 2) ? 1 : $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_d;
    logic [3:0]    r_word;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic          r_done;

    logic          w_sample;
    logic          w_last_phase;
    logic [3:0]    w_word_next;

    // A sample is taken at the end of each dwell window; the phase with
    // select==3 is the final one and ends the scan.
    assign w_sample     = (r_state == S_SCAN) && (r_cnt == LAST);
    assign w_last_phase = (r_sel == 2'd3);

    always_comb begin
        w_word_next        = r_word;
        w_word_next[r_sel] = q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_d     <= 4'd0;
            r_word  <= 4'd0;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_d     <= d_in;
                        r_sel   <= 2'd0;
                        r_cnt   <= '0;
                        r_word  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_sample) begin
                        r_cnt  <= '0;
                        r_word <= w_word_next;
                        r_sel  <= r_sel + 2'd1;  // wraps 3 -> 0 on the final sample
                        if (w_last_phase) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    logic r_err;

    // Loaded as the scan enters DONE, using the word value being written on
    // that same edge; cleared only by reset or the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_sample && w_last_phase) begin
            r_err <= (w_word_next != r_d);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign d      = r_d;
    assign select = r_sel;
    assign busy   = r_busy;
    assign done   = r_done;
    assign word   = r_word;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       q_force;

    logic       start1, start3;
    logic [3:0] d_in1, d_in3;
    logic       q1, q3;
    logic [3:0] d1, d3, word1, word3;
    logic [1:0] sel1, sel3;
    logic       busy1, busy3, done1, done3, err1, err3;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MUX_SCAN_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    always #5 clk = ~clk;

    // Behavioural downstream 4:1 mux; q_force models a stuck-at-0 output.
    assign q1 = q_force ? 1'b0 : d1[sel1];
    assign q3 = d3[sel3];

    mux_scan_ctrl #(.DWELL(1)) u_dw1 (
        .clk(clk), .rst(rst), .start(start1), .d_in(d_in1), .q(q1),
        .d(d1), .select(sel1), .busy(busy1), .done(done1), .word(word1), .err(err1)
    );

    mux_scan_ctrl #(.DWELL(3)) u_dw3 (
        .clk(clk), .rst(rst), .start(start3), .d_in(d_in3), .q(q3),
        .d(d3), .select(sel3), .busy(busy3), .done(done3), .word(word3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done1(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        int   ndone;
        int   cyc;
        int   last_cyc;
        logic [3:0] cap_word;

        rst = 1'b1; q_force = 1'b0;
        start1 = 1'b0; start3 = 1'b0; d_in1 = 4'd0; d_in3 = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_d",      32'(d1),     32'h0);
        chk("rst_sel",    32'(sel1),   32'h0);
        chk("rst_busy",   32'(busy1),  32'h0);
        chk("rst_done",   32'(done1),  32'h0);
        chk("rst_word",   32'(word1),  32'h0);
        chk("rst_err",    32'(err1),   32'h0);
        chk("rst_busy3",  32'(busy3),  32'h0);

        // DWELL=1, 1010, start on the first edge after reset release
        rst = 1'b0; start1 = 1'b1; d_in1 = 4'b1010;
        @(negedge clk);
        start1 = 1'b0;
        chk("dw1_sel0",  32'(sel1),  32'd0);
        chk("dw1_busy",  32'(busy1), 32'd1);
        chk("dw1_d",     32'(d1),    32'hA);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("dw1_sel",  32'(sel1),  32'(j));
            chk("dw1_nodn", 32'(done1), 32'd0);
        end
        @(negedge clk);
        chk("dw1_done",  32'(done1), 32'd1);
        chk("dw1_word",  32'(word1), 32'hA);
        chk("dw1_selw",  32'(sel1),  32'd0);
        chk("dw1_err",   32'(err1),  32'd0);
        @(negedge clk);
        chk("dw1_done_off", 32'(done1), 32'd0);
        chk("dw1_idle",     32'(busy1), 32'd0);
        repeat (3) @(negedge clk);
        chk("dw1_hold", 32'(word1), 32'hA);

        // DWELL=3, 0110: each select held 3 cycles, done 12 cycles after accept
        start3 = 1'b1; d_in3 = 4'b0110;
        @(negedge clk);
        start3 = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk("dw3_sel",  32'(sel3),  32'(j / 3));
            chk("dw3_nodn", 32'(done3), 32'd0);
            @(negedge clk);
        end
        chk("dw3_done", 32'(done3), 32'd1);
        chk("dw3_word", 32'(word3), 32'h6);

        // Sweep 0..15 with start held: 16 scans, done pulses 6 cycles apart
        @(negedge clk);
        start1 = 1'b1; d_in1 = 4'd0;
        ndone = 0; cyc = 0; last_cyc = 0;
        while (ndone < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done1) begin
                chk("sweep_word", 32'(word1), 32'(ndone));
                if (ndone > 0) chk("sweep_gap", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                ndone++;
                d_in1 = 4'(ndone);
            end
        end
        start1 = 1'b0;
        chk("sweep_count", 32'(ndone), 32'd16);
        repeat (2) @(negedge clk);

        // Reset while select==2 aborts the scan immediately
        start1 = 1'b1; d_in1 = 4'b1101;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_sel2", 32'(sel1), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("abort_d",    32'(d1),    32'h0);
        chk("abort_sel",  32'(sel1),  32'h0);
        chk("abort_busy", 32'(busy1), 32'h0);
        chk("abort_word", 32'(word1), 32'h0);
        chk("abort_done", 32'(done1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        start1 = 1'b1; d_in1 = 4'b0111;
        @(negedge clk);
        start1 = 1'b0;
        chk("post_abort_busy", 32'(busy1), 32'd1);
        wait_done1(seen);
        chk("post_abort_seen", 32'(seen),  32'd1);
        chk("post_abort_word", 32'(word1), 32'h7);

        // start re-pulsed during SCAN is ignored
        repeat (2) @(negedge clk);
        start1 = 1'b1; d_in1 = 4'b0011;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1; d_in1 = 4'b1100;
        @(negedge clk);
        start1 = 1'b0;
        ndone = 0; cap_word = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done1) begin
                ndone++;
                cap_word = word1;
            end
        end
        chk("ign_count", 32'(ndone),    32'd1);
        chk("ign_d",     32'(d1),       32'h3);
        chk("ign_word",  32'(cap_word), 32'h3);

        // q stuck at 0: word 0000, err per configuration, cleared on next start
        q_force = 1'b1; start1 = 1'b1; d_in1 = 4'b0001;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(seen);
        chk("stuck_seen", 32'(seen),  32'd1);
        chk("stuck_word", 32'(word1), 32'h0);
        chk("stuck_err",  32'(err1),  EXP_ERR);
        repeat (3) @(negedge clk);
        chk("stuck_err_hold", 32'(err1), EXP_ERR);
        q_force = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("clr_err",  32'(err1),  32'd0);
        chk("clr_word", 32'(word1), 32'h0);
        wait_done1(seen);
        chk("clr_seen",     32'(seen),  32'd1);
        chk("clr_word_fin", 32'(word1), 32'h1);
        chk("clr_err_fin",  32'(err1),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
